// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the maximal-length LFSR pattern generator.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package lfsr_pkg;

  localparam int LFSR_MIN_N = 2;
  localparam int LFSR_MAX_N = 32;

  // Low n bits set; covers the full-word case without overflowing the shift.
  function automatic logic [31:0] width_mask(input int n);
    if (n >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'h1 << n) - 32'h1;
  endfunction

  // Feedback tap mask for a maximal-length polynomial of degree n.
  // Bit k set means polynomial term x^(k+1) participates in the XOR.
  function automatic logic [31:0] tap_mask(input int n);
    case (n)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Seed truncated to n bits; an all-zero result would lock the LFSR, so use 1.
  function automatic logic [31:0] seed_norm(input int n, input logic [31:0] seed);
    logic [31:0] m;
    m = seed & width_mask(n);
    return (m != 32'h0) ? m : 32'h1;
  endfunction

endpackage

// File: rtl/lfsr_tpg.sv
// Free-running Fibonacci LFSR producing one N-bit pseudo-random pattern per enabled clock.
// Latency: dout is the state register itself; new pattern visible right after the enabled edge.
// Backpressure: none; en=0 freezes the state, en=1 resumes from the held value.
module lfsr_tpg
  import lfsr_pkg::*;
#(
  parameter int          N    = 20,
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [N-1:0] dout
);

  generate
    if (N < LFSR_MIN_N || N > LFSR_MAX_N) begin : g_bad_width
      $error("lfsr_tpg: N=%0d outside supported range %0d..%0d", N, LFSR_MIN_N, LFSR_MAX_N);
    end
  endgenerate

  localparam logic [N-1:0] SEED_EFF = N'(seed_norm(N, SEED));
  localparam logic [N-1:0] TAPS     = N'(tap_mask(N));
  localparam logic [N-1:0] ONE      = N'(1);

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;
  logic         fb;

  // Next state: hold, shift in the tap parity, or recover from the all-zero lock-up state.
  always_comb begin
    fb      = ^(state_q & TAPS);
    state_d = state_q;
    if (en) begin
      if (state_q == '0) begin
        state_d = ONE;
      end else begin
        state_d = {state_q[N-2:0], fb};
      end
    end
  end

  // State register; reset reloads the normalised seed without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign dout = state_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Randomised-enable bench for lfsr_tpg across several N/SEED configurations.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: en is driven randomly to exercise hold/resume.
module tb_lfsr_tpg;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        en    = 1'b0;
  logic [19:0] d20;
  logic [19:0] d20z;
  logic [19:0] d20o;
  logic [3:0]  d4;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one per instance.
  logic [31:0] m20, m4, m20z, m20o;

  always #5 clk = ~clk;

  lfsr_tpg #(.N(20), .SEED(32'd1))        u20  (.clk(clk), .rst_n(rst_n), .en(en), .dout(d20));
  lfsr_tpg #(.N(4),  .SEED(32'd1))        u4   (.clk(clk), .rst_n(rst_n), .en(en), .dout(d4));
  lfsr_tpg #(.N(20), .SEED(32'd0))        u20z (.clk(clk), .rst_n(rst_n), .en(en), .dout(d20z));
  lfsr_tpg #(.N(20), .SEED(32'h0010_0000)) u20o (.clk(clk), .rst_n(rst_n), .en(en), .dout(d20o));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int n);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] seed_eff(input int n, input logic [31:0] seed);
    return ((seed & wmask(n)) != 0) ? (seed & wmask(n)) : 32'h1;
  endfunction

  // Polynomial x^pa + x^pb + 1: new low bit is the XOR of state bits at positions pa, pb (1-indexed).
  function automatic logic [31:0] ref_next(input int n, input logic [31:0] s, input int pa, input int pb);
    logic [31:0] cur;
    logic [31:0] fb;
    cur = s & wmask(n);
    if (cur == 0) return 32'h1;
    fb = ((cur >> (pa - 1)) ^ (cur >> (pb - 1))) & 32'h1;
    return ((cur << 1) & wmask(n)) | fb;
  endfunction

  task automatic reset_models();
    m20  = seed_eff(20, 32'd1);
    m4   = seed_eff(4, 32'd1);
    m20z = seed_eff(20, 32'd0);
    m20o = seed_eff(20, 32'h0010_0000);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_n20"},  32'(d20),  m20);
    chk({tag, "_n4"},   32'(d4),   m4);
    chk({tag, "_s0"},   32'(d20z), m20z);
    chk({tag, "_sbig"}, 32'(d20o), m20o);
  endtask

  // One rising edge: advance the model when enabled, then compare away from the edge.
  task automatic tick_check(input string tag);
    @(posedge clk);
    if (en) begin
      m20  = ref_next(20, m20,  20, 17);
      m4   = ref_next(4,  m4,   4,  3);
      m20z = ref_next(20, m20z, 20, 17);
      m20o = ref_next(20, m20o, 20, 17);
    end
    #1;
    check_all(tag);
  endtask

  // Start of the sequence from seed 1 with the known values at clocks 16..20.
  task automatic run_known_prefix(input string tag);
    logic [31:0] known [5];
    known[0] = 32'h1_0000;
    known[1] = 32'h2_0001;
    known[2] = 32'h4_0002;
    known[3] = 32'h8_0004;
    known[4] = 32'h0_0009;
    en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick_check(tag);
      if (i >= 16) chk({tag, "_known"}, 32'(d20), known[i-16]);
    end
  endtask

  initial begin
    logic [15:0] seen;
    int          distinct;

    // Asynchronous reset asserted mid-cycle, before any rising edge.
    #2 rst_n = 1'b0;
    reset_models();
    #2 check_all("rst_async");
    #3 check_all("rst_hold");
    #1 rst_n = 1'b1;

    run_known_prefix("seq");

    // Enable dropped across one rising edge: state must hold, then resume with no skipped step.
    en = 1'b0;
    tick_check("hold");
    en = 1'b1;
    tick_check("resume");

    // Random enable pattern against the model.
    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick_check("rand");
    end

    // Reset pulse mid-run, between edges.
    en = 1'b1;
    #2 rst_n = 1'b0;
    reset_models();
    #1 check_all("rst_mid");
    #1 rst_n = 1'b1;
    run_known_prefix("seq2");

    // Period check on the 4-bit instance.
    #2 rst_n = 1'b0;
    reset_models();
    #1 rst_n = 1'b1;
    en       = 1'b1;
    seen     = 16'h0;
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      if (!seen[d4]) distinct++;
      seen[d4] = 1'b1;
      if (i < 14) tick_check("per4");
    end
    chk("per4_distinct", 32'(distinct), 32'd15);
    chk("per4_no_zero", 32'(seen[0]), 32'd0);
    tick_check("per4_last");
    chk("per4_wrap", 32'(d4), 32'h1);

    // Lock-up recovery: plant all-zero state while held, then enable one edge.
    en = 1'b0;
    force u20.state_q = '0;
    #1 release u20.state_q;
    m20 = 32'h0;
    en  = 1'b1;
    tick_check("lockup");
    chk("lockup_one", 32'(d20), 32'h1);
    for (int i = 0; i < 5; i++) begin
      en = ($urandom_range(0, 1) != 0);
      tick_check("post_lock");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
